// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-wide RAM port between instruction fetch and
// the load/store buffer. Fetch owns the port by default; an LSB request takes
// it over for a byte-serial load or store of 1, 2 or 4 bytes, and the port is
// handed back so fetch's in-flight byte is valid on its first unstalled cycle.
module mem_arbiter #(
   parameter logic [31:0] IO_BASE = 32'h00030000
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        clear,
   input  logic        io_buffer_full,
   input  logic [31:0] if_mem_a,
   input  logic        if_mem_wr,
   input  logic        lsb_req,
   input  logic        lsb_wr,
   input  logic [31:0] lsb_addr,
   input  logic [1:0]  lsb_size,
   input  logic        lsb_signed,
   input  logic [31:0] lsb_wdata,
   input  logic [7:0]  mem_din,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   output logic [7:0]  mem_dout,
   output logic        lsb_busy,
   output logic        lsb_done,
   output logic [31:0] lsb_rdata
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_READ   = 2'd1,
      S_WRITE  = 2'd2,
      S_REPLAY = 2'd3
   } state_t;

   state_t      r_state;
   logic [31:0] r_addr;
   logic [2:0]  r_n;
   logic        r_signed;
   logic [31:0] r_wdata;
   logic [2:0]  r_cnt;
   logic [31:0] r_buf;
   logic        r_busy;
   logic        r_done;
   logic [31:0] r_rdata;
   logic [7:0]  r_dout;

   logic [31:0] w_addr_cur;
   logic        w_io_stall;
   logic [31:0] w_asm;

   // Number of bytes moved for a given size code.
   function automatic logic [2:0] size_to_n(input logic [1:0] size);
      case (size)
         2'd0:    size_to_n = 3'd1;
         2'd1:    size_to_n = 3'd2;
         default: size_to_n = 3'd4;
      endcase
   endfunction

   // Zero- or sign-extend an assembled load from bit 8n-1.
   function automatic logic [31:0] extend(input logic [31:0] v,
                                          input logic [2:0]  n,
                                          input logic        sgn);
      case (n)
         3'd1:    extend = {{24{sgn & v[7]}}, v[7:0]};
         3'd2:    extend = {{16{sgn & v[15]}}, v[15:0]};
         default: extend = v;
      endcase
   endfunction

   // Select one little-endian byte lane of a word.
   function automatic logic [7:0] lane(input logic [31:0] d, input logic [2:0] idx);
      case (idx)
         3'd0:    lane = d[7:0];
         3'd1:    lane = d[15:8];
         3'd2:    lane = d[23:16];
         default: lane = d[31:24];
      endcase
   endfunction

   assign w_addr_cur = r_addr + {29'd0, r_cnt};
   assign w_io_stall = (r_addr[31:16] == IO_BASE[31:16]) && io_buffer_full;

   // Merge the byte arriving this cycle into lane cnt-1 of the load buffer.
   always_comb begin
      w_asm = r_buf;
      case (r_cnt)
         3'd1:    w_asm[7:0]   = mem_din;
         3'd2:    w_asm[15:8]  = mem_din;
         3'd3:    w_asm[23:16] = mem_din;
         3'd4:    w_asm[31:24] = mem_din;
         default: w_asm = r_buf;
      endcase
   end

   // RAM port mux: fetch by default, arbiter address while moving LSB bytes.
   always_comb begin
      mem_a  = if_mem_a;
      mem_wr = if_mem_wr;
      case (r_state)
         S_IDLE: begin
            mem_a  = if_mem_a;
            mem_wr = if_mem_wr;
         end
         S_READ: begin
            // Once all bytes are requested, present fetch's address so its byte
            // is on mem_din when fetch unfreezes; never read past addr+n-1.
            if (r_cnt < r_n) begin
               mem_a = w_addr_cur;
            end else begin
               mem_a = if_mem_a;
            end
            mem_wr = 1'b0;
         end
         S_WRITE: begin
            mem_a  = w_addr_cur;
            mem_wr = ~w_io_stall;
         end
         S_REPLAY: begin
            mem_a  = if_mem_a;
            mem_wr = 1'b0;
         end
         default: begin
            mem_a  = if_mem_a;
            mem_wr = 1'b0;
         end
      endcase
   end

   // Arbiter FSM: request capture, byte sequencing, completion and handback.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state  <= S_IDLE;
         r_addr   <= 32'd0;
         r_n      <= 3'd0;
         r_signed <= 1'b0;
         r_wdata  <= 32'd0;
         r_cnt    <= 3'd0;
         r_buf    <= 32'd0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_rdata  <= 32'd0;
         r_dout   <= 8'd0;
      end else if (rdy_in) begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (lsb_req && !clear) begin
                  r_addr   <= lsb_addr;
                  r_n      <= size_to_n(lsb_size);
                  r_signed <= lsb_signed;
                  r_wdata  <= lsb_wdata;
                  r_cnt    <= 3'd0;
                  r_buf    <= 32'd0;
                  r_busy   <= 1'b1;
                  r_dout   <= lsb_wdata[7:0];
                  r_state  <= lsb_wr ? S_WRITE : S_READ;
               end
            end
            S_READ: begin
               if (clear) begin
                  // Speculative load is dropped; fetch is restarting anyway.
                  r_busy  <= 1'b0;
                  r_cnt   <= 3'd0;
                  r_state <= S_IDLE;
               end else begin
                  if (r_cnt != 3'd0) begin
                     r_buf <= w_asm;
                  end
                  if (r_cnt == r_n) begin
                     r_rdata <= extend(w_asm, r_n, r_signed);
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= S_IDLE;
                  end else begin
                     r_cnt <= r_cnt + 3'd1;
                  end
               end
            end
            S_WRITE: begin
               // Committed stores ignore clear; a full UART buffer holds the byte.
               if (!w_io_stall) begin
                  if (r_cnt == (r_n - 3'd1)) begin
                     r_done  <= 1'b1;
                     r_state <= S_REPLAY;
                  end else begin
                     r_cnt  <= r_cnt + 3'd1;
                     r_dout <= lane(r_wdata, r_cnt + 3'd1);
                  end
               end
            end
            S_REPLAY: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign mem_dout  = r_dout;
   assign lsb_busy  = r_busy;
   assign lsb_done  = r_done;
   assign lsb_rdata = r_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a small byte-wide RAM model.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        clr;
   logic        io_full;
   logic [31:0] if_a;
   logic        if_wr;
   logic        req;
   logic        wr;
   logic [31:0] addr;
   logic [1:0]  size;
   logic        sgn;
   logic [31:0] wdata;
   logic [7:0]  mem_din;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic [7:0]  mem_dout;
   logic        busy;
   logic        done;
   logic [31:0] rdata;

   logic        pl_en = 1'b0;
   logic [19:0] pl_a  = 20'd0;
   logic [7:0]  pl_d  = 8'd0;

   logic [7:0]  ram [0:1048575];
   int          done_cnt  = 0;
   int          io_wr_cnt = 0;
   int          n_tests   = 0;
   int          n_fail    = 0;
   int          d0;

   mem_arbiter dut (
      .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear(clr),
      .io_buffer_full(io_full), .if_mem_a(if_a), .if_mem_wr(if_wr),
      .lsb_req(req), .lsb_wr(wr), .lsb_addr(addr), .lsb_size(size),
      .lsb_signed(sgn), .lsb_wdata(wdata), .mem_din(mem_din),
      .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout),
      .lsb_busy(busy), .lsb_done(done), .lsb_rdata(rdata)
   );

   always #5 clk = ~clk;

   // RAM model: one-cycle read latency, synchronous write, bench preload port.
   always @(posedge clk) begin
      mem_din <= ram[mem_a[19:0]];
      if (mem_wr) ram[mem_a[19:0]] <= mem_dout;
      if (pl_en) ram[pl_a] <= pl_d;
      if (done) done_cnt <= done_cnt + 1;
      if (mem_wr && mem_a == 32'h00030000) io_wr_cnt <= io_wr_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [19:0] a, input logic [7:0] d);
      pl_en = 1'b1; pl_a = a; pl_d = d;
      tick();
      pl_en = 1'b0;
   endtask

   task automatic request(input logic w, input logic [31:0] a, input logic [1:0] s,
                          input logic sg, input logic [31:0] wd);
      req = 1'b1; wr = w; addr = a; size = s; sgn = sg; wdata = wd;
      tick();
      req = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; clr = 1'b0; io_full = 1'b0;
      if_a = 32'h100; if_wr = 1'b0; req = 1'b0; wr = 1'b0;
      addr = 32'd0; size = 2'd0; sgn = 1'b0; wdata = 32'd0;
      tick(); tick();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_dout", {24'd0, mem_dout}, 32'd0);
      rst = 1'b0;

      // Idle passthrough
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_a", mem_a, 32'h100);
         chk("idle_wr", {31'd0, mem_wr}, 32'd0);
         chk("idle_busy", {31'd0, busy}, 32'd0);
      end

      preload(20'h00200, 8'h78); preload(20'h00201, 8'h56);
      preload(20'h00202, 8'h34); preload(20'h00203, 8'h12);
      preload(20'h00300, 8'h80); preload(20'h00402, 8'hEE);

      // Word load
      request(1'b0, 32'h200, 2'd2, 1'b0, 32'd0);
      chk("wl_a0", mem_a, 32'h200);
      chk("wl_busy", {31'd0, busy}, 32'd1);
      tick(); chk("wl_a1", mem_a, 32'h201);
      tick(); chk("wl_a2", mem_a, 32'h202);
      tick(); chk("wl_a3", mem_a, 32'h203);
      chk("wl_wr", {31'd0, mem_wr}, 32'd0);
      tick(); chk("wl_handback", mem_a, 32'h100);
      chk("wl_busy4", {31'd0, busy}, 32'd1);
      chk("wl_nodone", {31'd0, done}, 32'd0);
      tick(); chk("wl_done", {31'd0, done}, 32'd1);
      chk("wl_rdata", rdata, 32'h12345678);
      chk("wl_busy_lo", {31'd0, busy}, 32'd0);
      tick(); chk("wl_done_pulse", {31'd0, done}, 32'd0);

      // Signed / unsigned byte load
      request(1'b0, 32'h300, 2'd0, 1'b1, 32'd0);
      chk("sb_a0", mem_a, 32'h300);
      tick(); chk("sb_handback", mem_a, 32'h100);
      tick(); chk("sb_done", {31'd0, done}, 32'd1);
      chk("sb_rdata", rdata, 32'hFFFFFF80);
      tick();
      request(1'b0, 32'h300, 2'd0, 1'b0, 32'd0);
      tick(); tick();
      chk("ub_done", {31'd0, done}, 32'd1);
      chk("ub_rdata", rdata, 32'h00000080);
      tick();

      // Half store with replay
      request(1'b1, 32'h400, 2'd1, 1'b0, 32'hAABBCCDD);
      chk("hs_a0", mem_a, 32'h400);
      chk("hs_wr0", {31'd0, mem_wr}, 32'd1);
      chk("hs_d0", {24'd0, mem_dout}, 32'hDD);
      tick(); chk("hs_a1", mem_a, 32'h401);
      chk("hs_d1", {24'd0, mem_dout}, 32'hCC);
      tick(); chk("hs_done", {31'd0, done}, 32'd1);
      chk("hs_replay_a", mem_a, 32'h100);
      chk("hs_replay_wr", {31'd0, mem_wr}, 32'd0);
      chk("hs_replay_busy", {31'd0, busy}, 32'd1);
      tick(); chk("hs_busy_lo", {31'd0, busy}, 32'd0);
      chk("hs_ram400", {24'd0, ram[20'h00400]}, 32'hDD);
      chk("hs_ram401", {24'd0, ram[20'h00401]}, 32'hCC);
      chk("hs_ram402", {24'd0, ram[20'h00402]}, 32'hEE);

      // IO stall
      d0 = done_cnt;
      io_full = 1'b1;
      request(1'b1, 32'h00030000, 2'd0, 1'b0, 32'h0000005A);
      for (int i = 0; i < 3; i++) begin
         chk("io_stall_wr", {31'd0, mem_wr}, 32'd0);
         chk("io_stall_a", mem_a, 32'h00030000);
         chk("io_stall_done", {31'd0, done}, 32'd0);
         if (i < 2) tick();
      end
      io_full = 1'b0;
      #1;
      chk("io_go_wr", {31'd0, mem_wr}, 32'd1);
      chk("io_go_d", {24'd0, mem_dout}, 32'h5A);
      tick(); chk("io_done", {31'd0, done}, 32'd1);
      tick(); chk("io_busy_lo", {31'd0, busy}, 32'd0);
      chk("io_writes", io_wr_cnt, 32'd1);
      chk("io_done_once", done_cnt - d0, 32'd1);
      chk("io_ram", {24'd0, ram[20'h30000]}, 32'h5A);

      // Clear during load
      d0 = done_cnt;
      request(1'b0, 32'h200, 2'd2, 1'b0, 32'd0);
      tick(); tick();
      chk("cl_a2", mem_a, 32'h202);
      clr = 1'b1;
      tick(); clr = 1'b0;
      chk("cl_busy", {31'd0, busy}, 32'd0);
      chk("cl_a", mem_a, 32'h100);
      tick(); tick();
      chk("cl_nodone", done_cnt - d0, 32'd0);

      // Clear during store: store still completes
      d0 = done_cnt;
      request(1'b1, 32'h500, 2'd3, 1'b0, 32'h11223344);
      clr = 1'b1;
      tick(); tick(); tick();
      chk("cs_a3", mem_a, 32'h503);
      chk("cs_d3", {24'd0, mem_dout}, 32'h11);
      tick(); chk("cs_done", {31'd0, done}, 32'd1);
      tick(); chk("cs_busy_lo", {31'd0, busy}, 32'd0);
      chk("cs_done_once", done_cnt - d0, 32'd1);
      chk("cs_ram500", {24'd0, ram[20'h00500]}, 32'h44);
      chk("cs_ram503", {24'd0, ram[20'h00503]}, 32'h11);

      // Clear in IDLE blocks the request
      req = 1'b1; wr = 1'b0; addr = 32'h300; size = 2'd0; sgn = 1'b1;
      tick();
      chk("ci_blocked", {31'd0, busy}, 32'd0);
      clr = 1'b0;
      tick(); req = 1'b0;
      chk("ci_accept", {31'd0, busy}, 32'd1);
      tick(); tick();
      chk("ci_rdata", rdata, 32'hFFFFFF80);
      tick();

      // rdy_in low freezes the transfer
      request(1'b0, 32'h200, 2'd2, 1'b0, 32'd0);
      rdy = 1'b0;
      tick(); tick();
      chk("rdy_a_hold", mem_a, 32'h200);
      chk("rdy_busy", {31'd0, busy}, 32'd1);
      rdy = 1'b1;
      tick(); tick(); tick(); tick(); tick();
      chk("rdy_done", {31'd0, done}, 32'd1);
      chk("rdy_rdata", rdata, 32'h12345678);
      tick();

      // Address wrap-around
      request(1'b0, 32'hFFFFFFFF, 2'd1, 1'b0, 32'd0);
      chk("wrap_a0", mem_a, 32'hFFFFFFFF);
      tick(); chk("wrap_a1", mem_a, 32'h00000000);
      tick(); tick();
      chk("wrap_done", {31'd0, done}, 32'd1);
      tick();

      // Asynchronous reset mid-load
      request(1'b0, 32'h200, 2'd2, 1'b0, 32'd0);
      tick();
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_a", mem_a, 32'h100);
      rst = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits between the byte-wide RAM port and its two clients: the instruction fetch stage and the load/store buffer (LSB).
- By default the fetch stage's address and write strobe pass straight through to RAM.
- On an LSB request, the arbiter takes the port and performs a byte-serial load or store of 1, 2 or 4 bytes.
- While it owns the port it holds `lsb_busy` high, which stalls fetch (fetch `from_lsb`). It hands the port back so that fetch's in-flight byte is valid on the first unstalled cycle.

Parameters:
- IO_BASE, 32'h00030000, base of the memory-mapped IO window. A write with addr[31:16] equal to IO_BASE[31:16] is an IO write.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  asynchronous reset, active-high
- rdy_in  input  1  global enable; 0 freezes all state
- clear  input  1  pipeline flush from ROB
- io_buffer_full  input  1  UART buffer full; stalls IO writes
- if_mem_a  input  32  fetch-stage byte address
- if_mem_wr  input  1  fetch-stage write strobe (always 0; passed through)
- lsb_req  input  1  LSB request strobe, sampled only in IDLE
- lsb_wr  input  1  1 = store, 0 = load
- lsb_addr  input  32  first byte address
- lsb_size  input  2  0 = byte, 1 = half, 2 or 3 = word
- lsb_signed  input  1  sign-extend loads narrower than a word
- lsb_wdata  input  32  store data, little-endian
- mem_din  input  8  RAM read data; valid one cycle after mem_a
- mem_a  output  32  RAM address (combinational mux)
- mem_wr  output  1  RAM write enable (combinational mux)
- mem_dout  output  8  RAM write data
- lsb_busy  output  1  arbiter owns the port; drives fetch `from_lsb`
- lsb_done  output  1  one-cycle completion pulse
- lsb_rdata  output  32  load result, valid while lsb_done = 1

Behaviour:
- Reset (async, any state): state = IDLE; lsb_busy = 0; lsb_done = 0; lsb_rdata = 0; cnt = 0; mem_dout = 0.
- rdy_in = 0: no register changes. Muxed outputs still follow the current state.
- Byte count n: 1, 2 or 4 from lsb_size. cnt is 3 bits.
- lsb_done defaults to 0 every enabled edge. It is never high for more than one cycle.
- IDLE:
  - mem_a = if_mem_a, mem_wr = if_mem_wr.
  - When lsb_req = 1 and clear = 0 at an edge:
    - latch wr, addr, n, signed and wdata;
    - set cnt = 0 and lsb_busy = 1;
    - go to READ or WRITE.
  - Fetch sees lsb_busy = 0 at that same edge and advances one last time. From the next edge it is frozen.
- READ:
  - mem_a = addr + cnt while cnt < n; mem_a = if_mem_a when cnt == n. mem_wr = 0 throughout.
  - Each edge with cnt > 0 stores mem_din into byte lane cnt-1. Each edge increments cnt.
  - At the edge where cnt == n:
    - lsb_rdata = assembled value, zero- or sign-extended from bit 8n-1;
    - lsb_done = 1, lsb_busy = 0, go to IDLE.
    - The next cycle mem_din holds the byte at if_mem_a, as the unfrozen fetch stage expects.
  - No address beyond addr+n-1 is ever presented. This avoids side-effect reads in the IO window.
  - Load latency from the request edge: n+1 cycles to lsb_done.
- WRITE:
  - mem_a = addr + cnt, mem_wr = 1, mem_dout = wdata byte lane cnt.
  - If the latched address is in the IO window and io_buffer_full = 1:
    - force mem_wr = 0 and hold cnt;
    - retry every cycle until io_buffer_full = 0.
  - Otherwise cnt increments each edge. The edge that writes byte n-1 sets lsb_done = 1 and goes to REPLAY.
- REPLAY (one cycle):
  - mem_a = if_mem_a, mem_wr = 0, lsb_busy still 1.
  - Next edge: lsb_busy = 0, go to IDLE.
  - Store takes n+1 cycles busy after the request edge, plus any IO stall cycles.
- Transitions at the edge leaving REPLAY, or on entry to IDLE from READ, ignore lsb_req. A new request is accepted at the earliest on the edge after returning to IDLE.
- clear:
  - In READ: abort immediately to IDLE with lsb_busy = 0 and no lsb_done. The speculative load is discarded; fetch is resetting and ignores mem_din.
  - In WRITE or REPLAY: ignored. Committed stores always complete, and lsb_done still pulses.
  - In IDLE: blocks acceptance of lsb_req that cycle.
- Reset mid-operation: immediate return to IDLE. Partial stores are not rolled back.
- Address arithmetic: 32-bit wrap-around (0xFFFFFFFF + 1 = 0).

Test Plan:
- Idle passthrough: if_mem_a = 0x100, no request -> mem_a = 0x100, mem_wr = 0, lsb_busy = 0 for 10 cycles.
- Word load: RAM[0x200..0x203] = 78,56,34,12; size = 2 -> mem_a = 0x200..0x203 then if_mem_a; lsb_done at request+5; lsb_rdata = 0x12345678; lsb_busy low in the cycle after the if_mem_a presentation.
- Signed byte load: RAM[0x300] = 0x80; size = 0, signed = 1 -> lsb_rdata = 0xFFFFFF80. With signed = 0 -> 0x00000080.
- Half store with replay: addr = 0x400, wdata = 0xAABBCCDD, size = 1 -> writes DD@0x400 then CC@0x401 (mem_wr = 1); one REPLAY cycle shows if_mem_a with mem_wr = 0; RAM[0x402] unchanged.
- IO stall: byte store to 0x30000 with io_buffer_full = 1 for 3 cycles -> mem_wr = 0 for those cycles, then one write of the byte; lsb_done exactly once.
- Clear during load: word load; clear asserted at cnt = 2 -> IDLE next cycle, no lsb_done, lsb_busy = 0. Clear during a store -> store completes and lsb_done pulses.
